// File: rtl/apb_acc_vec_pkg.sv
// Shared constants, FSM state type and width helpers for the APB vector accelerator.
package acc_vec_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_LEN    = 12'h008;
    localparam logic [11:0] OFF_DOT_LO = 12'h00C;
    localparam logic [11:0] OFF_DOT_HI = 12'h010;
    localparam logic [11:0] OFF_A_BANK = 12'h100;
    localparam logic [11:0] OFF_B_BANK = 12'h400;
    localparam logic [11:0] OFF_R_BANK = 12'h800;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_SIGNED = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Sum of n_elem full-width products can never overflow this width.
    function automatic int acc_width(input int elem_w, input int n_elem);
        return 2 * elem_w + $clog2(n_elem);
    endfunction

    function automatic int elem_per_word(input int elem_w);
        return 32 / elem_w;
    endfunction

endpackage

// File: rtl/apb_acc_vec_if.sv
// APB slave signal bundle for the vector accelerator.
interface apb_acc_vec_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_acc_vec_datapath.sv
// LANES parallel multipliers (signed/unsigned) and an adder tree producing one partial sum.
module acc_vec_datapath
    import acc_vec_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int SUM_W  = 20
) (
    input  logic [LANES-1:0][ELEM_W-1:0]   a,
    input  logic [LANES-1:0][ELEM_W-1:0]   b,
    input  logic                           is_signed,
    output logic [LANES-1:0][2*ELEM_W-1:0] prod,
    output logic [SUM_W-1:0]               psum
);
    localparam int PW = 2 * ELEM_W;

    logic [LANES-1:0][SUM_W-1:0] ext;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PW+1:0] ax;
        logic signed [PW+1:0] bx;
        logic signed [PW+1:0] px;

        // One extra operand bit lets a single signed multiplier cover both modes.
        assign ax      = (PW+2)'($signed({is_signed & a[l][ELEM_W-1], a[l]}));
        assign bx      = (PW+2)'($signed({is_signed & b[l][ELEM_W-1], b[l]}));
        assign px      = ax * bx;
        assign prod[l] = px[PW-1:0];
        assign ext[l]  = SUM_W'(px);
    end

    always_comb begin
        psum = '0;
        for (int l = 0; l < LANES; l++) begin
            psum = psum + ext[l];
        end
    end
endmodule

// File: rtl/apb_acc_vec.sv
// APB-mapped vector accelerator: operand/result banks, register decode, run FSM, accumulator.
// state | meaning
// IDLE  | waiting for a START with a legal LEN
// RUN   | LANES elements multiplied per cycle, idx advances by LANES
// FIN   | DONE is set on the edge leaving this state, back to IDLE
module apb_acc_vec
    import acc_vec_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_ELEM         = 16,
    parameter int ELEM_W         = 8,
    parameter int LANES          = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    apb_acc_vec_if.slave  apb,
    output logic          irq_o
);
    localparam int EPW     = elem_per_word(ELEM_W);
    localparam int RPW     = EPW / 2;
    localparam int PW      = 2 * ELEM_W;
    localparam int ACC_W   = acc_width(ELEM_W, N_ELEM);
    localparam int EI_W    = $clog2(N_ELEM);
    localparam int A_WORDS = N_ELEM / EPW;
    localparam int R_WORDS = N_ELEM / RPW;

    localparam logic [9:0] WA_A     = OFF_A_BANK[11:2];
    localparam logic [9:0] WA_B     = OFF_B_BANK[11:2];
    localparam logic [9:0] WA_R     = OFF_R_BANK[11:2];
    localparam logic [9:0] WA_A_END = WA_A + 10'(A_WORDS);
    localparam logic [9:0] WA_B_END = WA_B + 10'(A_WORDS);
    localparam logic [9:0] WA_R_END = WA_R + 10'(R_WORDS);

    state_t state_q, state_d;

    logic [N_ELEM-1:0][ELEM_W-1:0] a_mem, b_mem;
    logic [N_ELEM-1:0][PW-1:0]     r_mem;
    logic [ACC_W-1:0]              acc_q;
    logic [31:0]                   len_q, idx_q;
    logic                          ctrl_mode, ctrl_signed, ctrl_irq_en;
    logic                          st_done, st_err;

    logic [9:0]  wa, a_wi, b_wi, r_wi;
    logic        acc_wr, wr_ok, slverr, busy;
    logic        hit_ctrl, hit_status, hit_len, hit_dot_lo, hit_dot_hi, hit_a, hit_b, hit_r;
    logic        len_ok, start_req, start_go, start_bad, last_beat;
    logic [63:0] dot64;
    logic [31:0] rdata;
    logic        unused_addr_lsb;

    logic [LANES-1:0][ELEM_W-1:0] dp_a, dp_b;
    logic [LANES-1:0][PW-1:0]     dp_prod;
    logic [ACC_W-1:0]             dp_psum;

    assign wa         = apb.PADDR[11:2];
    assign unused_addr_lsb = ^apb.PADDR[1:0];
    assign acc_wr     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign busy       = (state_q != IDLE);

    assign hit_ctrl   = (wa == OFF_CTRL[11:2]);
    assign hit_status = (wa == OFF_STATUS[11:2]);
    assign hit_len    = (wa == OFF_LEN[11:2]);
    assign hit_dot_lo = (wa == OFF_DOT_LO[11:2]);
    assign hit_dot_hi = (wa == OFF_DOT_HI[11:2]);
    assign hit_a      = (wa >= WA_A) && (wa < WA_A_END);
    assign hit_b      = (wa >= WA_B) && (wa < WA_B_END);
    assign hit_r      = (wa >= WA_R) && (wa < WA_R_END);
    assign a_wi       = wa - WA_A;
    assign b_wi       = wa - WA_B;
    assign r_wi       = wa - WA_R;

    always_comb begin
        slverr = 1'b0;
        if (acc_wr) begin
            if (hit_r || hit_dot_lo || hit_dot_hi) begin
                slverr = 1'b1;
            end else if (busy && (hit_a || hit_b || hit_len || hit_ctrl)) begin
                slverr = 1'b1;
            end
        end
    end

    assign wr_ok     = acc_wr & ~slverr;
    assign len_ok    = (len_q != 32'd0) && (len_q <= 32'(N_ELEM));
    assign start_req = wr_ok & hit_ctrl & apb.PWDATA[CTRL_START];
    assign start_go  = start_req & len_ok;
    assign start_bad = start_req & ~len_ok;
    assign last_beat = (idx_q + 32'(LANES)) >= len_q;

    assign dot64 = ctrl_signed ? {{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                               : {{(64-ACC_W){1'b0}}, acc_q};

    always_comb begin
        rdata = 32'hFFFF_FFFF;
        if (hit_ctrl) begin
            rdata = {28'd0, ctrl_irq_en, ctrl_signed, ctrl_mode, 1'b0};
        end else if (hit_status) begin
            rdata = {29'd0, st_err, st_done, busy};
        end else if (hit_len) begin
            rdata = len_q;
        end else if (hit_dot_lo) begin
            rdata = dot64[31:0];
        end else if (hit_dot_hi) begin
            rdata = dot64[63:32];
        end else if (hit_a) begin
            rdata = a_mem[EI_W'(a_wi * EPW) +: EPW];
        end else if (hit_b) begin
            rdata = b_mem[EI_W'(b_wi * EPW) +: EPW];
        end else if (hit_r) begin
            rdata = r_mem[EI_W'(r_wi * RPW) +: RPW];
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = slverr;
    assign irq_o       = st_done & ctrl_irq_en;

    // Lanes past LEN get a zero operand, so their product and contribution are zero.
    always_comb begin
        dp_a = a_mem[EI_W'(idx_q) +: LANES];
        dp_b = b_mem[EI_W'(idx_q) +: LANES];
        for (int l = 0; l < LANES; l++) begin
            if ((idx_q + 32'(l)) >= len_q) begin
                dp_a[l] = '0;
            end
        end
    end

    acc_vec_datapath #(
        .LANES (LANES),
        .ELEM_W(ELEM_W),
        .SUM_W (ACC_W)
    ) u_datapath (
        .a        (dp_a),
        .b        (dp_b),
        .is_signed(ctrl_signed),
        .prod     (dp_prod),
        .psum     (dp_psum)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RUN;
            RUN:     if (last_beat) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_mem       <= '0;
            b_mem       <= '0;
            r_mem       <= '0;
            acc_q       <= '0;
            len_q       <= 32'(N_ELEM);
            idx_q       <= '0;
            ctrl_mode   <= 1'b0;
            ctrl_signed <= 1'b0;
            ctrl_irq_en <= 1'b0;
            st_done     <= 1'b0;
            st_err      <= 1'b0;
        end else begin
            if (wr_ok && hit_a) a_mem[EI_W'(a_wi * EPW) +: EPW] <= apb.PWDATA;
            if (wr_ok && hit_b) b_mem[EI_W'(b_wi * EPW) +: EPW] <= apb.PWDATA;
            if (wr_ok && hit_len) len_q <= apb.PWDATA;
            if (wr_ok && hit_ctrl && !start_bad) begin
                ctrl_mode   <= apb.PWDATA[CTRL_MODE];
                ctrl_signed <= apb.PWDATA[CTRL_SIGNED];
                ctrl_irq_en <= apb.PWDATA[CTRL_IRQ_EN];
            end
            if (wr_ok && hit_status) begin
                if (apb.PWDATA[ST_DONE]) st_done <= 1'b0;
                if (apb.PWDATA[ST_ERR])  st_err  <= 1'b0;
            end
            if (start_bad) st_err <= 1'b1;
            // R is cleared at START so elements beyond LEN read back as zero.
            if (start_go) begin
                idx_q   <= '0;
                acc_q   <= '0;
                r_mem   <= '0;
                st_done <= 1'b0;
            end
            if (state_q == RUN) begin
                r_mem[EI_W'(idx_q) +: LANES] <= dp_prod;
                if (ctrl_mode) acc_q <= acc_q + dp_psum;
                idx_q <= idx_q + 32'(LANES);
            end
            if (state_q == FIN) st_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_acc_vec.sv
// Randomised self-checking bench for apb_acc_vec against a behavioural vector model.
module tb_apb_acc_vec;
    localparam int N = 16;
    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_LEN    = 12'h008;
    localparam logic [11:0] A_DOT_LO = 12'h00C;
    localparam logic [11:0] A_DOT_HI = 12'h010;
    localparam logic [11:0] A_ABANK  = 12'h100;
    localparam logic [11:0] A_BBANK  = 12'h400;
    localparam logic [11:0] A_RBANK  = 12'h800;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic irq_o;

    apb_acc_vec_if #(.APB_ADDR_WIDTH(12)) bus();

    apb_acc_vec #(
        .APB_ADDR_WIDTH(12),
        .N_ELEM        (16),
        .ELEM_W        (8),
        .LANES         (4)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .apb    (bus),
        .irq_o  (irq_o)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    logic [7:0]  ma [N];
    logic [7:0]  mb [N];
    logic [15:0] mr [N];
    longint      mdot;
    int          mlen;
    logic        last_ready;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data, output logic err);
        bus.PADDR = addr; bus.PWDATA = data; bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        #1 err = bus.PSLVERR;
        @(posedge HCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] addr, output logic [31:0] data, output logic err);
        bus.PADDR = addr; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        #1;
        data = bus.PRDATA; err = bus.PSLVERR; last_ready = bus.PREADY;
        @(posedge HCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic e;
        apb_wr(addr, data, e);
        check_val("wr_slverr", 64'(e), 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(addr, d, e);
        check_val(tag, 64'(d), 64'(exp));
    endtask

    // Counts cycles with STATUS.BUSY set, bounded so a stuck engine still reaches the summary.
    task automatic wait_idle(output int cyc);
        logic [31:0] s;
        bus.PADDR = A_STATUS;
        cyc = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            s = bus.PRDATA;
            if (!s[0]) break;
            cyc++;
            @(posedge HCLK); #1;
        end
    endtask

    task automatic model_run(input logic mode, input logic sgn);
        longint p;
        mdot = 0;
        for (int i = 0; i < N; i++) begin
            if (i < mlen) begin
                if (sgn) p = longint'($signed(ma[i])) * longint'($signed(mb[i]));
                else     p = longint'(ma[i]) * longint'(mb[i]);
                mr[i] = p[15:0];
                if (mode) mdot += p;
            end else begin
                mr[i] = '0;
            end
        end
    endtask

    task automatic load_banks();
        for (int w = 0; w < N / 4; w++) begin
            wr(12'(A_ABANK + 4 * w), {ma[4*w+3], ma[4*w+2], ma[4*w+1], ma[4*w]});
            wr(12'(A_BBANK + 4 * w), {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
        end
    endtask

    task automatic run_op(input logic mode, input logic sgn, input logic ien, input string tag);
        int cyc;
        logic [63:0] d64;
        wr(A_LEN, 32'(mlen));
        wr(A_CTRL, {28'd0, ien, sgn, mode, 1'b1});
        wait_idle(cyc);
        model_run(mode, sgn);
        check_val({tag, "_busy"}, 64'(cyc), 64'((mlen + 3) / 4 + 1));
        for (int w = 0; w < N / 2; w++) begin
            rd_chk({tag, "_r"}, 12'(A_RBANK + 4 * w), {mr[2*w+1], mr[2*w]});
        end
        d64 = mdot;
        rd_chk({tag, "_dot_lo"}, A_DOT_LO, d64[31:0]);
        rd_chk({tag, "_dot_hi"}, A_DOT_HI, d64[63:32]);
        rd_chk({tag, "_status"}, A_STATUS, 32'h2);
        check_val({tag, "_irq"}, 64'(irq_o), 64'(ien));
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int          cyc;

        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_status", A_STATUS, 32'h0);
        rd_chk("rst_len", A_LEN, 32'd16);
        rd_chk("rst_dot_lo", A_DOT_LO, 32'h0);
        check_val("rst_irq", 64'(irq_o), 64'd0);

        for (int i = 0; i < N; i++) begin ma[i] = 8'(i + 1); mb[i] = 8'd2; end
        mlen = 16;
        load_banks();
        run_op(1'b0, 1'b0, 1'b0, "ew");
        rd_chk("ew_r0_const", A_RBANK, 32'h0004_0002);
        wr(A_CTRL, 32'h8);
        check_val("irq_en_on", 64'(irq_o), 64'd1);
        wr(A_STATUS, 32'h2);
        check_val("irq_done_clr", 64'(irq_o), 64'd0);
        rd_chk("done_w1c", A_STATUS, 32'h0);

        for (int i = 0; i < N; i++) begin ma[i] = 8'hFF; mb[i] = 8'h7F; end
        load_banks();
        run_op(1'b1, 1'b1, 1'b0, "dot_s");
        rd_chk("dot_s_lo_const", A_DOT_LO, 32'hFFFF_F810);
        rd_chk("dot_s_hi_const", A_DOT_HI, 32'hFFFF_FFFF);

        for (int i = 0; i < N; i++) begin ma[i] = 8'd3; mb[i] = 8'd3; end
        mlen = 5;
        load_banks();
        run_op(1'b1, 1'b0, 1'b1, "part");
        rd_chk("part_lo_const", A_DOT_LO, 32'd45);

        wr(A_STATUS, 32'h6);
        wr(A_LEN, 32'd0);
        wr(A_CTRL, 32'h1);
        rd_chk("err_len0", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4);
        rd_chk("err_w1c", A_STATUS, 32'h0);
        wr(A_LEN, 32'd17);
        wr(A_CTRL, 32'h1);
        rd_chk("err_len17", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4);
        apb_wr(A_RBANK, 32'h1234_5678, e);
        check_val("slverr_r", 64'(e), 64'd1);
        apb_wr(A_DOT_LO, 32'h1, e);
        check_val("slverr_dot", 64'(e), 64'd1);

        mlen = 16;
        wr(A_LEN, 32'd16);
        wr(A_CTRL, 32'h1);
        apb_wr(A_ABANK, 32'hDEAD_BEEF, e);
        check_val("slverr_a_busy", 64'(e), 64'd1);
        apb_wr(A_LEN, 32'd3, e);
        check_val("slverr_len_busy", 64'(e), 64'd1);
        wait_idle(cyc);
        model_run(1'b0, 1'b0);
        rd_chk("a_unchanged", A_ABANK, {ma[3], ma[2], ma[1], ma[0]});
        rd_chk("len_unchanged", A_LEN, 32'd16);

        for (int t = 0; t < 12; t++) begin
            logic md, sg, ie;
            for (int i = 0; i < N; i++) begin
                ma[i] = 8'($urandom);
                mb[i] = 8'($urandom);
            end
            mlen = $urandom_range(1, 16);
            md = 1'($urandom); sg = 1'($urandom); ie = 1'($urandom);
            load_banks();
            run_op(md, sg, ie, "rnd");
        end

        mlen = 16;
        wr(A_LEN, 32'd16);
        wr(A_CTRL, 32'h3);
        @(posedge HCLK); #1 HRESETn = 1'b0;
        @(posedge HCLK); #1 HRESETn = 1'b1;
        for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
        rd_chk("mid_rst_status", A_STATUS, 32'h0);
        rd_chk("mid_rst_dot_lo", A_DOT_LO, 32'h0);
        rd_chk("mid_rst_dot_hi", A_DOT_HI, 32'h0);
        rd_chk("mid_rst_len", A_LEN, 32'd16);
        rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
        for (int w = 0; w < N / 4; w++) begin
            rd_chk("mid_rst_a", 12'(A_ABANK + 4 * w), 32'h0);
        end
        rd_chk("mid_rst_r0", A_RBANK, 32'h0);
        check_val("mid_rst_irq", 64'(irq_o), 64'd0);

        apb_rd(12'hFFC, d, e);
        check_val("unmap_rdata", 64'(d), 64'hFFFF_FFFF);
        check_val("unmap_slverr", 64'(e), 64'd0);
        check_val("unmap_pready", 64'(last_ready), 64'd1);
        wr(12'hFFC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
